// File: rtl/refresh_scheduler_if.sv
// Command-side signals between the refresh scheduler and Refresh_SM / bus arbiter.
// Refresh_Signal is a one-cycle trigger; the scheduler raises no further trigger until Refresh_Done returns.
interface refresh_scheduler_if;
  logic       Bus_Busy;
  logic       Refresh_Done;
  logic       Refresh_Signal;
  logic       Refresh_Urgent;
  logic [3:0] Pending_Count;
  logic       Overflow_Err;

  modport master (
    input  Bus_Busy,
    input  Refresh_Done,
    output Refresh_Signal,
    output Refresh_Urgent,
    output Pending_Count,
    output Overflow_Err
  );

  modport slave (
    output Bus_Busy,
    output Refresh_Done,
    input  Refresh_Signal,
    input  Refresh_Urgent,
    input  Pending_Count,
    input  Overflow_Err
  );
endinterface

// File: rtl/refresh_scheduler.sv
// SDRAM auto-refresh scheduler: owes one refresh per TREFI cycles, issues them one at a time.
// Define REFRESH_POSTPONE_EN to defer refresh while Bus_Busy is high until pending reaches URGENT_LEVEL.
module refresh_scheduler #(
  parameter int TREFI        = 780,
  parameter int MAX_PENDING  = 8,
  parameter int URGENT_LEVEL = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  refresh_scheduler_if.master  bus,
  output logic [1:0]           state_o
);

  localparam int CW = (TREFI > 1) ? $clog2(TREFI) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pending_q, pending_d;
  logic            ovf_q, ovf_d;
  logic            tick;
  logic            go_issue;
  logic            refresh_signal;
  logic            done_acc;

  assign tick = (cnt_q == CW'(TREFI - 1));

`ifdef REFRESH_POSTPONE_EN
  logic urgent_q;
  assign go_issue = (pending_q != 4'd0) &&
                    (!bus.Bus_Busy || (pending_q >= 4'(URGENT_LEVEL)));
`else
  logic unused_bus_busy;
  assign unused_bus_busy = bus.Bus_Busy;
  assign go_issue        = (pending_q != 4'd0);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (go_issue) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (bus.Refresh_Done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs; Refresh_Done only counts while a refresh is outstanding
  always_comb begin
    refresh_signal = 1'b0;
    done_acc       = 1'b0;
    case (state_q)
      ISSUE:     refresh_signal = 1'b1;
      WAIT_DONE: done_acc       = bus.Refresh_Done;
      default:   ;
    endcase
  end

  // A tick and a completion in the same cycle cancel out
  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (tick && !done_acc) begin
      if (pending_q < 4'(MAX_PENDING)) pending_d = pending_q + 4'd1;
      else                             ovf_d     = 1'b1;
    end else if (!tick && done_acc) begin
      pending_d = pending_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 4'd0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef REFRESH_POSTPONE_EN
  // Compared on the next pending value so the flag lines up with Pending_Count
  always_ff @(posedge clk) begin
    if (rst) urgent_q <= 1'b0;
    else     urgent_q <= (pending_d >= 4'(URGENT_LEVEL));
  end
  assign bus.Refresh_Urgent = urgent_q;
`else
  assign bus.Refresh_Urgent = 1'b0;
`endif

  assign bus.Refresh_Signal = refresh_signal;
  assign bus.Pending_Count  = pending_q;
  assign bus.Overflow_Err   = ovf_q;
  assign state_o            = state_q;

endmodule
